or1200_enc_pad_gen_ctrl: RTL and testbench

// - Producer side of the CTR/OFB encryption-pad path: accepts an IV/seed, drives the block-cipher core

---
 rtl/or1200_enc_pad_gen_ctrl_pkg.sv | 30 +++
 rtl/or1200_enc_pad_gen_ctrl_if.sv | 45 ++++
 rtl/or1200_enc_pad_gen_ctrl_buf.sv | 114 +++++++++++
 rtl/or1200_enc_pad_gen_ctrl.sv | 140 ++++++++++++++
 tb/tb_or1200_enc_pad_gen_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/or1200_enc_pad_gen_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// or1200_enc_pad_gen_ctrl_pkg
// Shared definitions for the encryption-pad generator controller:
//   - FSM state encoding (IDLE/ISSUE/WAIT/HOLD/DRAIN)
//   - CTR/OFB mode constants
//   - pad buffer depth, selected by OR1200_ENC_PAD_PREFETCH_EN
//     (defined: 2-entry pad FIFO, undefined: single pad register)
// ---------------------------------------------------------------------------
package or1200_enc_pad_gen_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic MODE_CTR = 1'b0;
  localparam logic MODE_OFB = 1'b1;

  localparam int unsigned PAD_CNT_W = 2;

`ifdef OR1200_ENC_PAD_PREFETCH_EN
  localparam logic [PAD_CNT_W-1:0] PAD_DEPTH = 2'd2;
`else
  localparam logic [PAD_CNT_W-1:0] PAD_DEPTH = 2'd1;
`endif

endpackage

// File: rtl/or1200_enc_pad_gen_ctrl_if.sv
// ---------------------------------------------------------------------------
// or1200_enc_pad_gen_ctrl_if
// Bundles the seed, cipher-core and pad handshakes of the pad generator.
//   slave  : the controller (drives seed_ready/seed_read/enc_*/pad_* outputs)
//   master : the environment (seed source, cipher core, pad consumer)
// Signals:
//   flush                       abort current seed, drop held pads
//   seed_valid/ready/data/mode/nblk, seed_read   seed acceptance
//   enc_start/enc_in, enc_done/enc_out           cipher core
//   pad_valid/ready/data/first                   pad output
// ---------------------------------------------------------------------------
interface or1200_enc_pad_gen_ctrl_if #(
  parameter int DW  = 128,
  parameter int NBW = 8
);
  logic           flush;
  logic           seed_valid;
  logic           seed_ready;
  logic [DW-1:0]  seed_data;
  logic           seed_mode;
  logic [NBW-1:0] seed_nblk;
  logic           seed_read;
  logic           enc_start;
  logic [DW-1:0]  enc_in;
  logic           enc_done;
  logic [DW-1:0]  enc_out;
  logic           pad_valid;
  logic           pad_ready;
  logic [DW-1:0]  pad_data;
  logic           pad_first;

  modport slave (
    input  flush, seed_valid, seed_data, seed_mode, seed_nblk,
           enc_done, enc_out, pad_ready,
    output seed_ready, seed_read, enc_start, enc_in,
           pad_valid, pad_data, pad_first
  );

  modport master (
    output flush, seed_valid, seed_data, seed_mode, seed_nblk,
           enc_done, enc_out, pad_ready,
    input  seed_ready, seed_read, enc_start, enc_in,
           pad_valid, pad_data, pad_first
  );
endinterface

// File: rtl/or1200_enc_pad_gen_ctrl_buf.sv
// ---------------------------------------------------------------------------
// or1200_enc_pad_buf
// Pad buffer holding pad data plus its first-of-seed flag.
// OR1200_ENC_PAD_PREFETCH_EN defined: 2-entry FIFO (head in slot 0).
// Undefined: single pad register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_flush         empty the buffer
//   i_push/i_data/i_first   write one pad (caller guarantees a free slot)
//   o_valid/i_ready/o_data/o_first   consumer handshake; o_first is
//                                    qualified by o_valid
//   o_count         number of pads held
// ---------------------------------------------------------------------------
module or1200_enc_pad_buf
  import or1200_enc_pad_gen_ctrl_pkg::*;
#(
  parameter int DW = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_push,
  input  logic [DW-1:0]        i_data,
  input  logic                 i_first,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DW-1:0]        o_data,
  output logic                 o_first,
  output logic [PAD_CNT_W-1:0] o_count
);

  logic [PAD_CNT_W-1:0] r_count;
  logic [DW-1:0]        r_data0;
  logic                 r_first0;
  logic                 w_pop;

  assign w_pop = (r_count != 2'd0) && i_ready;

`ifdef OR1200_ENC_PAD_PREFETCH_EN
  logic [DW-1:0] r_data1;
  logic          r_first1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_data0  <= '0;
      r_first0 <= 1'b0;
      r_data1  <= '0;
      r_first1 <= 1'b0;
    end else if (i_flush) begin
      r_count  <= 2'd0;
      r_first0 <= 1'b0;
      r_first1 <= 1'b0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data0  <= i_data;
            r_first0 <= i_first;
          end else begin
            r_data1  <= i_data;
            r_first1 <= i_first;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0  <= r_data1;
          r_first0 <= r_first1;
          r_first1 <= 1'b0;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          // Count unchanged: head leaves, new pad lands behind the survivor.
          if (r_count == 2'd1) begin
            r_data0  <= i_data;
            r_first0 <= i_first;
          end else begin
            r_data0  <= r_data1;
            r_first0 <= r_first1;
            r_data1  <= i_data;
            r_first1 <= i_first;
          end
        end
        default: ;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_data0  <= '0;
      r_first0 <= 1'b0;
    end else if (i_flush) begin
      r_count  <= 2'd0;
      r_first0 <= 1'b0;
    end else begin
      if (i_push) begin
        r_data0  <= i_data;
        r_first0 <= i_first;
        r_count  <= 2'd1;
      end else if (w_pop) begin
        r_count  <= 2'd0;
      end
    end
  end
`endif

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data0;
  assign o_first = o_valid & r_first0;
  assign o_count = r_count;

endmodule

// File: rtl/or1200_enc_pad_gen_ctrl.sv
// ---------------------------------------------------------------------------
// or1200_enc_pad_gen_ctrl
// Producer side of the CTR/OFB encryption-pad path. Accepts an IV/seed,
// issues successive blocks to the cipher core and hands the results to the
// memory-encryption XOR datapath as pads, tagging the first pad of a seed.
// Config macro: OR1200_ENC_PAD_PREFETCH_EN (2-entry pad buffer, next cipher
// op may start while a pad is still held).
// Parameters: DW block width, CW CTR counter width (low bits), NBW pad count.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   or1200_enc_pad_gen_ctrl_if.slave: flush, seed handshake,
//         cipher start/done, pad handshake
// ---------------------------------------------------------------------------
module or1200_enc_pad_gen_ctrl
  import or1200_enc_pad_gen_ctrl_pkg::*;
#(
  parameter int DW  = 128,
  parameter int CW  = 32,
  parameter int NBW = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  or1200_enc_pad_gen_ctrl_if.slave  bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DW-1:0]        r_blk;
  logic                 r_mode;
  logic [NBW-1:0]       r_left;
  logic                 r_first_pend;

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [NBW-1:0]       w_left_dec;
  logic [PAD_CNT_W-1:0] w_cnt;
  logic [PAD_CNT_W-1:0] w_cnt_after;
  logic                 w_buf_valid;
  logic                 w_buf_first;
  logic [DW-1:0]        w_buf_data;

  // CTR step: only the low CW bits count, wrapping; upper bits are the nonce.
  function automatic logic [DW-1:0] f_ctr_next(input logic [DW-1:0] b);
    logic [DW-1:0] n;
    n         = b;
    n[CW-1:0] = b[CW-1:0] + CW'(1);
    return n;
  endfunction

  // A flushing cycle never accepts a seed.
  assign w_accept   = (r_state == ST_IDLE) && !bus.flush && bus.seed_valid;
  assign w_push     = (r_state == ST_WAIT) && bus.enc_done && !bus.flush;
  assign w_pop      = w_buf_valid && bus.pad_ready && !bus.flush;
  assign w_left_dec = r_left - NBW'(1);
  // Buffer occupancy as it will be after this edge.
  assign w_cnt_after = w_cnt - {1'b0, w_pop} + {1'b0, w_push};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (bus.seed_nblk != '0)) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.enc_done) begin
          if ((w_left_dec != '0) && (w_cnt_after < PAD_DEPTH)) w_state_nxt = ST_ISSUE;
          else                                                 w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_left != '0) begin
          if (w_cnt_after < PAD_DEPTH) w_state_nxt = ST_ISSUE;
        end else if (w_cnt_after == 2'd0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.enc_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A cipher op still in flight must be swallowed before the next seed.
    if (bus.flush) begin
      if (((r_state == ST_WAIT) || (r_state == ST_DRAIN)) && !bus.enc_done)
        w_state_nxt = ST_DRAIN;
      else
        w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_blk        <= '0;
      r_mode       <= MODE_CTR;
      r_left       <= '0;
      r_first_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_blk        <= bus.seed_data;
        r_mode       <= bus.seed_mode;
        r_left       <= bus.seed_nblk;
        r_first_pend <= 1'b1;
      end else if (w_push) begin
        r_blk        <= (r_mode == MODE_OFB) ? bus.enc_out : f_ctr_next(r_blk);
        r_left       <= w_left_dec;
        r_first_pend <= 1'b0;
      end
    end
  end

  or1200_enc_pad_buf #(
    .DW (DW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.flush),
    .i_push  (w_push),
    .i_data  (bus.enc_out),
    .i_first (r_first_pend),
    .o_valid (w_buf_valid),
    .i_ready (bus.pad_ready),
    .o_data  (w_buf_data),
    .o_first (w_buf_first),
    .o_count (w_cnt)
  );

  assign bus.seed_ready = (r_state == ST_IDLE) && !bus.flush;
  assign bus.seed_read  = w_accept;
  assign bus.enc_start  = (r_state == ST_ISSUE) && !bus.flush;
  assign bus.enc_in     = r_blk;
  assign bus.pad_valid  = w_buf_valid;
  assign bus.pad_data   = w_buf_data;
  assign bus.pad_first  = w_buf_first;

endmodule

// File: tb/tb_or1200_enc_pad_gen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_or1200_enc_pad_gen_ctrl
// Directed bench: a per-cycle vector table for the CTR / nblk=0 / flush-in-
// IDLE flow, then hand-written sequences for OFB, backpressure, flush during
// a cipher op and reset while a pad is held.
// ---------------------------------------------------------------------------
module tb_or1200_enc_pad_gen_ctrl;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  or1200_enc_pad_gen_ctrl_if #(.DW(128), .NBW(8)) bus ();

  or1200_enc_pad_gen_ctrl #(.DW(128), .CW(32), .NBW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  typedef struct {
    logic         sv;
    logic [127:0] sd;
    logic         sm;
    logic [7:0]   nb;
    logic         ed;
    logic [127:0] eo;
    logic         pr;
    logic         fl;
    logic         e_sr;
    logic         e_rd;
    logic         e_st;
    logic [127:0] e_in;
    logic         e_pv;
    logic         e_pf;
    logic [127:0] e_pd;
  } vec_t;

  localparam logic [127:0] Z  = 128'h0;
  localparam logic [127:0] S0 = 128'h0123_4567_89AB_CDEF_0011_2233_FFFF_FFFE;
  localparam logic [127:0] S1 = 128'h0123_4567_89AB_CDEF_0011_2233_FFFF_FFFF;
  localparam logic [127:0] S2 = 128'h0123_4567_89AB_CDEF_0011_2233_0000_0000;
  localparam logic [127:0] S3 = 128'h0123_4567_89AB_CDEF_0011_2233_0000_0001;
  localparam logic [127:0] P0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] P1 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_0000_1111;
  localparam logic [127:0] P2 = 128'h2468_ACE0_1357_9BDF_0F0F_F0F0_5A5A_A5A5;
  localparam logic [127:0] D5 = 128'h5;
  localparam logic [127:0] D0 = 128'hDEAD_BEEF_CAFE_F00D_0000_0000_1234_5678;
  localparam logic [127:0] VA = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0001;
  localparam logic [127:0] VB = 128'hBBBB_1111_BBBB_1111_BBBB_1111_BBBB_1112;
  localparam logic [127:0] VQ = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [127:0] VR = 128'h7777_7777_7777_7777_7777_7777_7777_7777;

  vec_t tbl [18];

  function automatic vec_t mk(
    input logic sv, input logic [127:0] sd, input logic sm, input logic [7:0] nb,
    input logic ed, input logic [127:0] eo, input logic pr, input logic fl,
    input logic e_sr, input logic e_rd, input logic e_st, input logic [127:0] e_in,
    input logic e_pv, input logic e_pf, input logic [127:0] e_pd);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sm = sm; v.nb = nb; v.ed = ed; v.eo = eo; v.pr = pr; v.fl = fl;
    v.e_sr = e_sr; v.e_rd = e_rd; v.e_st = e_st; v.e_in = e_in;
    v.e_pv = e_pv; v.e_pf = e_pf; v.e_pd = e_pd;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.flush      = 1'b0;
    bus.seed_valid = 1'b0;
    bus.seed_data  = '0;
    bus.seed_mode  = 1'b0;
    bus.seed_nblk  = '0;
    bus.enc_done   = 1'b0;
    bus.enc_out    = '0;
    bus.pad_ready  = 1'b0;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic give_seed(input logic [127:0] d, input logic m, input logic [7:0] nb);
    idle_in();
    bus.seed_valid = 1'b1;
    bus.seed_data  = d;
    bus.seed_mode  = m;
    bus.seed_nblk  = nb;
  endtask

  int n_st;
  int exp_extra;

  initial begin
    n_err = 0;
    n_chk = 0;
    idle_in();
    rst = 1'b1;

    //           sv  sd  sm nb    ed  eo  pr  fl | sr  rd  st  in  pv  pf  pd
    tbl[0]  = mk(0,  Z,  0, 8'd0, 0,  Z,  0,  0,   1,  0,  0,  Z,  0,  0,  Z);
    tbl[1]  = mk(1,  S0, 0, 8'd3, 0,  Z,  0,  0,   1,  1,  0,  Z,  0,  0,  Z);
    tbl[2]  = mk(0,  Z,  0, 8'd0, 0,  Z,  0,  0,   0,  0,  1,  S0, 0,  0,  Z);
    tbl[3]  = mk(0,  Z,  0, 8'd0, 0,  Z,  0,  0,   0,  0,  0,  S0, 0,  0,  Z);
    tbl[4]  = mk(0,  Z,  0, 8'd0, 1,  P0, 0,  0,   0,  0,  0,  S0, 0,  0,  Z);
    tbl[5]  = mk(0,  Z,  0, 8'd0, 0,  Z,  0,  0,   0,  0,  0,  S1, 1,  1,  P0);
    tbl[6]  = mk(0,  Z,  0, 8'd0, 0,  Z,  1,  0,   0,  0,  0,  S1, 1,  1,  P0);
    tbl[7]  = mk(0,  Z,  0, 8'd0, 0,  Z,  0,  0,   0,  0,  1,  S1, 0,  0,  Z);
    tbl[8]  = mk(0,  Z,  0, 8'd0, 1,  P1, 0,  0,   0,  0,  0,  S1, 0,  0,  Z);
    tbl[9]  = mk(0,  Z,  0, 8'd0, 0,  Z,  1,  0,   0,  0,  0,  S2, 1,  0,  P1);
    tbl[10] = mk(0,  Z,  0, 8'd0, 0,  Z,  0,  0,   0,  0,  1,  S2, 0,  0,  Z);
    tbl[11] = mk(0,  Z,  0, 8'd0, 1,  P2, 0,  0,   0,  0,  0,  S2, 0,  0,  Z);
    tbl[12] = mk(0,  Z,  0, 8'd0, 0,  Z,  1,  0,   0,  0,  0,  S3, 1,  0,  P2);
    tbl[13] = mk(0,  Z,  0, 8'd0, 1,  P0, 0,  0,   1,  0,  0,  S3, 0,  0,  Z);
    tbl[14] = mk(1,  D5, 0, 8'd0, 0,  Z,  0,  0,   1,  1,  0,  S3, 0,  0,  Z);
    tbl[15] = mk(0,  Z,  0, 8'd0, 0,  Z,  0,  0,   1,  0,  0,  D5, 0,  0,  Z);
    tbl[16] = mk(1,  S0, 0, 8'd1, 0,  Z,  0,  1,   0,  0,  0,  D5, 0,  0,  Z);
    tbl[17] = mk(0,  Z,  0, 8'd0, 0,  Z,  0,  0,   1,  0,  0,  D5, 0,  0,  Z);

    // Reset state while rst is held.
    nx();
    @(negedge clk);
    chk1("reset seed_ready", bus.seed_ready, 1'b1);
    chk1("reset pad_valid",  bus.pad_valid,  1'b0);
    chk1("reset pad_first",  bus.pad_first,  1'b0);
    chk1("reset enc_start",  bus.enc_start,  1'b0);
    chk1("reset seed_read",  bus.seed_read,  1'b0);
    chkw("reset enc_in",     bus.enc_in,     Z);
    chkw("reset pad_data",   bus.pad_data,   Z);
    nx();
    rst = 1'b0;

    // Table: CTR nblk=3 with counter wrap, stray enc_done, nblk=0, flush+seed.
    for (int i = 0; i < 18; i++) begin
      bus.seed_valid = tbl[i].sv;
      bus.seed_data  = tbl[i].sd;
      bus.seed_mode  = tbl[i].sm;
      bus.seed_nblk  = tbl[i].nb;
      bus.enc_done   = tbl[i].ed;
      bus.enc_out    = tbl[i].eo;
      bus.pad_ready  = tbl[i].pr;
      bus.flush      = tbl[i].fl;
      @(negedge clk);
      chk1($sformatf("row%0d seed_ready", i), bus.seed_ready, tbl[i].e_sr);
      chk1($sformatf("row%0d seed_read",  i), bus.seed_read,  tbl[i].e_rd);
      chk1($sformatf("row%0d enc_start",  i), bus.enc_start,  tbl[i].e_st);
      chkw($sformatf("row%0d enc_in",     i), bus.enc_in,     tbl[i].e_in);
      chk1($sformatf("row%0d pad_valid",  i), bus.pad_valid,  tbl[i].e_pv);
      chk1($sformatf("row%0d pad_first",  i), bus.pad_first,  tbl[i].e_pf);
      if (tbl[i].e_pv)
        chkw($sformatf("row%0d pad_data", i), bus.pad_data, tbl[i].e_pd);
      nx();
    end
    idle_in();

    // OFB, nblk=2: core returns VA then VB.
    give_seed(D0, 1'b1, 8'd2);
    @(negedge clk);
    chk1("ofb seed_read", bus.seed_read, 1'b1);
    nx(); idle_in();
    @(negedge clk);
    chk1("ofb start0", bus.enc_start, 1'b1);
    chkw("ofb in0",    bus.enc_in,    D0);
    nx(); bus.enc_done = 1'b1; bus.enc_out = VA;
    nx(); idle_in(); bus.pad_ready = 1'b1;
    @(negedge clk);
    chk1("ofb pv0", bus.pad_valid, 1'b1);
    chkw("ofb pd0", bus.pad_data,  VA);
    chk1("ofb pf0", bus.pad_first, 1'b1);
    nx(); idle_in();
    @(negedge clk);
    chk1("ofb start1", bus.enc_start, 1'b1);
    chkw("ofb in1",    bus.enc_in,    VA);
    nx(); bus.enc_done = 1'b1; bus.enc_out = VB;
    nx(); idle_in(); bus.pad_ready = 1'b1;
    @(negedge clk);
    chk1("ofb pv1", bus.pad_valid, 1'b1);
    chkw("ofb pd1", bus.pad_data,  VB);
    chk1("ofb pf1", bus.pad_first, 1'b0);
    nx(); idle_in();
    @(negedge clk);
    chk1("ofb end seed_ready", bus.seed_ready, 1'b1);
    chk1("ofb end pad_valid",  bus.pad_valid,  1'b0);
    nx();

    // Backpressure: pad held for 5 cycles with pad_ready low.
`ifdef OR1200_ENC_PAD_PREFETCH_EN
    exp_extra = 1;
`else
    exp_extra = 0;
`endif
    give_seed(D0, 1'b0, 8'd2);
    nx(); idle_in();
    nx(); bus.enc_done = 1'b1; bus.enc_out = VQ;
    nx(); idle_in();
    n_st = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1($sformatf("bp%0d pad_valid", k), bus.pad_valid, 1'b1);
      chkw($sformatf("bp%0d pad_data",  k), bus.pad_data,  VQ);
      chk1($sformatf("bp%0d pad_first", k), bus.pad_first, 1'b1);
      if (bus.enc_start) n_st++;
      nx();
    end
    chkw("bp extra enc_start", 128'(n_st), 128'(exp_extra));
    bus.flush = 1'b1;
    nx(); idle_in(); bus.enc_done = 1'b1; bus.enc_out = VR;
    nx(); idle_in();
    @(negedge clk);
    chk1("bp cleanup seed_ready", bus.seed_ready, 1'b1);
    chk1("bp cleanup pad_valid",  bus.pad_valid,  1'b0);
    nx();

    // Flush while the cipher op is in flight.
    give_seed(D0, 1'b0, 8'd1);
    nx(); idle_in();
    @(negedge clk);
    chk1("fw start", bus.enc_start, 1'b1);
    nx(); bus.flush = 1'b1;
    nx(); idle_in();
    @(negedge clk);
    chk1("fw drain seed_ready0", bus.seed_ready, 1'b0);
    nx();
    @(negedge clk);
    chk1("fw drain seed_ready1", bus.seed_ready, 1'b0);
    nx(); bus.enc_done = 1'b1; bus.enc_out = VR;
    @(negedge clk);
    chk1("fw done seed_ready", bus.seed_ready, 1'b0);
    nx(); idle_in();
    @(negedge clk);
    chk1("fw after seed_ready", bus.seed_ready, 1'b1);
    chk1("fw after pad_valid",  bus.pad_valid,  1'b0);
    chk1("fw after enc_start",  bus.enc_start,  1'b0);
    nx();
    @(negedge clk);
    chk1("fw later pad_valid", bus.pad_valid, 1'b0);
    nx();

    // Reset while a pad is held, then a stray enc_done.
    give_seed(D0, 1'b0, 8'd2);
    nx(); idle_in();
    nx(); bus.enc_done = 1'b1; bus.enc_out = VQ;
    nx(); idle_in();
    @(negedge clk);
    chk1("rh hold pad_valid", bus.pad_valid, 1'b1);
    rst = 1'b1;
    nx(); rst = 1'b0;
    @(negedge clk);
    chk1("rh pad_valid",  bus.pad_valid,  1'b0);
    chk1("rh seed_ready", bus.seed_ready, 1'b1);
    chk1("rh pad_first",  bus.pad_first,  1'b0);
    bus.enc_done = 1'b1; bus.enc_out = VR;
    nx(); idle_in();
    @(negedge clk);
    chk1("rh stray pad_valid",  bus.pad_valid,  1'b0);
    chk1("rh stray seed_ready", bus.seed_ready, 1'b1);
    chk1("rh stray enc_start",  bus.enc_start,  1'b0);
    chkw("rh stray enc_in",     bus.enc_in,     Z);
    nx();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
